// File: rtl/uart_rx_deser.sv
// UART receive deserialiser: synchronises the rx pin, times bit centres with a
// clock-divided baud counter, assembles LSB-first data bits and presents each
// byte on a valid/ready port. Flags framing errors and overruns.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_deser #(
    parameter int unsigned CLK_FREQ         = 50000000,
    parameter int unsigned BAUD             = 115200,
    parameter int unsigned DATA_BYTE_LENGTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rx,
    output logic [DATA_BYTE_LENGTH-1:0] data,
    output logic                        data_valid,
    input  logic                        data_ready,
    output logic                        frame_err,
    output logic                        overrun,
    output logic                        parity_err
);

    localparam int unsigned DIV   = CLK_FREQ / BAUD;
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BIT_W = (DATA_BYTE_LENGTH > 1) ? $clog2(DATA_BYTE_LENGTH) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(DATA_BYTE_LENGTH - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_START  = 5'b00010,
        S_DATA   = 5'b00100,
        S_STOP   = 5'b01000,
        S_PARITY = 5'b10000
    } state_e;
`else
    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_START = 4'b0010,
        S_DATA  = 4'b0100,
        S_STOP  = 4'b1000
    } state_e;
`endif

    state_e state_q, state_d;

    logic                        rx_meta_q;
    logic                        rx_s_q;
    logic                        rx_prev_q;
    logic                        rx_fall;

    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [BIT_W-1:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_BYTE_LENGTH-1:0] shift_q, shift_d;

    logic [DATA_BYTE_LENGTH-1:0] data_q, data_d;
    logic                        valid_q, valid_d;
    logic                        frame_err_q, frame_err_d;
    logic                        overrun_q, overrun_d;

    logic                        stop_sample;
    logic                        par_bad;
    logic                        deliver;

    // Two-flop synchroniser plus a history flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign rx_fall = rx_prev_q & ~rx_s_q;

`ifdef UART_RX_PARITY_EN
    logic parity_bit_q, parity_bit_d;
    logic parity_err_q, parity_err_d;

    // Parity bit capture and parity error pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_bit_q <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            parity_bit_q <= parity_bit_d;
            parity_err_q <= parity_err_d;
        end
    end

    // Even parity: data bits together with the parity bit must XOR to zero.
    assign par_bad      = ^{shift_q, parity_bit_q};
    assign parity_err_d = stop_sample & rx_s_q & par_bad;
    assign parity_err   = parity_err_q;
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    // Receive FSM and datapath state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    // Next-state logic: bit-centre timing, data sampling and stop detection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_d = parity_bit_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (rx_fall) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF_END) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    // A start bit that is high again at its centre is a glitch.
                    state_d   = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d              = '0;
                    shift_d[bit_cnt_q] = rx_s_q;
                    bit_cnt_d          = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d        = '0;
                    parity_bit_d = rx_s_q;
                    state_d      = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d       = '0;
                    stop_sample = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // A frame is good when its stop bit is high and its parity (if any) checks.
    assign deliver     = stop_sample & rx_s_q & ~par_bad;
    assign frame_err_d = stop_sample & ~rx_s_q;

    // Output port: accept a new byte if empty or being drained this cycle.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (deliver && (!valid_q || data_ready)) begin
            data_d  = shift_q;
            valid_d = 1'b1;
        end else begin
            if (valid_q && data_ready) begin
                valid_d = 1'b0;
            end
            overrun_d = deliver;
        end
    end

    // Output registers and one-cycle error pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
- Downstream companion of the UART receive-state sequencer.
- Takes the raw asynchronous rx line and times bit centres with a clock-divided baud counter.
- Assembles LSB-first data bits into a byte and presents it on a valid/ready output port.
- Flags framing errors and overruns; sits between the board RX pin and the byte consumer (FIFO or command parser).

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line bit rate.
- DATA_BYTE_LENGTH, 8, data bits per frame (5..8).

Ports:
- clk, input, 1, system clock; all logic on posedge.
- rst_n, input, 1, reset; synchronous, active-low.
- rx, input, 1, asynchronous serial line; idle high.
- data, output, DATA_BYTE_LENGTH, received byte, LSB = first bit on the line.
- data_valid, output, 1, data holds an unconsumed byte.
- data_ready, input, 1, consumer accepts data when data_valid && data_ready.
- frame_err, output, 1, one-cycle pulse: stop bit sampled low.
- overrun, output, 1, one-cycle pulse: new byte lost because the output was still full.
- parity_err, output, 1, one-cycle pulse on parity mismatch (tied 0 without macro).

Behaviour:
- Derived constants: DIV = CLK_FREQ/BAUD (integer), HALF = DIV/2. Baud counter width = clog2(DIV).
- Synchroniser:
  - rx passes through 2 flops (rx_s), reset to 1.
  - Falling edge = previous rx_s 1, current rx_s 0.
- Reset (rst_n=0 at a clk edge):
  - state=S_IDLE, data=0, data_valid=0, frame_err=0, overrun=0, parity_err=0, counters=0, shift register=0.
  - Applies mid-frame; a partial byte is discarded.
- State encoding is one-hot: S_IDLE=0001, S_START=0010, S_DATA=0100, S_STOP=1000 (S_PARITY=10000 when enabled; state widens to 5 bits).
- S_IDLE: on falling edge of rx_s, clear the baud counter and go to S_START.
- S_START: count to HALF-1, then sample rx_s.
  - rx_s=0: go to S_DATA, clear counters.
  - rx_s=1: glitch; return to S_IDLE with no output.
- S_DATA: every DIV cycles, sample rx_s into shift register bit [bit_cnt]; bit_cnt increments.
  - After sample DATA_BYTE_LENGTH-1, go to S_STOP (or S_PARITY).
- S_STOP: after DIV cycles, sample rx_s, then always go to S_IDLE.
  - rx_s=1 (good frame): deliver the byte.
  - rx_s=0: frame_err=1 for one cycle; byte dropped.
  - No extra wait for line high; IDLE re-arms only on a true falling edge.
- Delivery, registered and visible the cycle after the stop sample:
  - Output empty (data_valid=0), or accepted this same cycle (data_valid && data_ready): data <= byte, data_valid <= 1.
  - Otherwise: overrun=1 for one cycle; data and data_valid unchanged; new byte dropped.
- Handshake:
  - data_valid falls the cycle after data_valid && data_ready, unless a new byte is delivered that same cycle (valid stays 1, data updates).
  - data is stable while data_valid=1 and data_ready=0.
- Latency, rx pin to data_valid: 2 (sync) + HALF + DATA_BYTE_LENGTH·DIV + DIV + 1 cycles from the start-bit falling edge.
- Error pulses are never asserted at the same time as delivery of the same frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - One even-parity bit follows the data bits; state S_PARITY samples it DIV cycles after the last data bit, then goes to S_STOP.
  - If XOR(data bits, parity bit) = 1, parity_err pulses one cycle at the stop sample and the byte is dropped.
  - A frame error takes priority; only frame_err pulses.
- Undefined: no parity bit, S_PARITY absent, parity_err constant 0.

Test Plan:
- All scenarios use CLK_FREQ=1600000, BAUD=100000 (DIV=16, HALF=8), no macro unless stated.
- Frame 0xA5 with data_ready=1 -> data=0xA5, data_valid high exactly 1 cycle, no error pulses.
- rx low for 4 cycles then high -> state returns to S_IDLE; data_valid, frame_err and overrun stay 0.
- Frame 0x3C with stop bit driven 0 -> frame_err pulses one cycle; data_valid stays 0.
- data_ready=0; frames 0x11 then 0x22 -> data=0x11 held valid; overrun pulses once at the second stop; data remains 0x11.
- rst_n=0 for 1 cycle after 4th data bit of 0xFF, then full frame 0x5A -> only 0x5A delivered, no error pulses.
- Macro defined; 0x07 with parity 1 -> delivered; 0x07 with parity 0 -> parity_err pulse, no data_valid.
